// File: rtl/sipo_deser_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sipo_deser_pkg
//  Description : Shared types and helpers for the SIPO deserializer: the
//                collector state encoding and the bit-count width function.
//                Optional macro: SIPO_DESER_PARITY_EN (adds the PARITY state).
//  Revision    : 1.0 - initial release
// ============================================================================
package sipo_deser_pkg;

`ifdef SIPO_DESER_PARITY_EN
    typedef enum logic [0:0] {
        ST_SHIFT  = 1'b0,
        ST_PARITY = 1'b1
    } state_t;
`else
    typedef enum logic [0:0] {
        ST_SHIFT  = 1'b0
    } state_t;
`endif

    // Bits needed to count 0..width inclusive (count reaches WIDTH while the
    // parity bit is awaited).
    function automatic int count_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sipo_out_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : sipo_out_buffer
//  Description : One-entry valid/ready holding register for completed words,
//                with a sticky overrun flag for words that arrive while the
//                held word is still unconsumed.
//  Revision    : 1.0 - initial release
// ============================================================================
module sipo_out_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_perr,
    input  logic             out_ready,
    input  logic             clr_overrun,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             out_perr,
    output logic             overrun
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_perr;
    logic             r_overrun;

    logic             w_load;
    logic             w_drop;

    // A new word may enter when the slot is empty or is being drained on the
    // same edge; otherwise it is lost and the overrun flag records that.
    assign w_load = in_valid && (!r_valid || out_ready);
    assign w_drop = in_valid && r_valid && !out_ready;

    // Holding register: load wins over drain so back-to-back words stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
        end else if (w_load) begin
            r_data  <= in_data;
            r_valid <= 1'b1;
            r_perr  <= in_perr;
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Sticky overrun: a fresh drop outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (clr_overrun) begin
            r_overrun <= 1'b0;
        end
    end

    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign out_perr  = r_perr;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: rtl/sipo_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : sipo_deserializer
//  Description : LSB-first serial-to-parallel converter with frame_start
//                resynchronisation and a one-entry valid/ready output slot.
//                Optional macro: SIPO_DESER_PARITY_EN (even parity bit after
//                each word, reported on out_perr; tied to 0 otherwise).
//  Revision    : 1.0 - initial release
// ============================================================================
module sipo_deserializer
    import sipo_deser_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          serial_in,
    input  logic                          bit_valid,
    input  logic                          frame_start,
    input  logic                          out_ready,
    input  logic                          clr_overrun,
    output logic [WIDTH-1:0]              parallel_out,
    output logic                          out_valid,
    output logic                          out_perr,
    output logic                          overrun,
    output logic [count_width(WIDTH)-1:0] bit_count
);

    localparam int            c_cw       = count_width(WIDTH);
    localparam logic [c_cw-1:0] c_one      = c_cw'(1);
    localparam logic [c_cw-1:0] c_last_idx = c_cw'(WIDTH - 1);
`ifdef SIPO_DESER_PARITY_EN
    localparam logic [c_cw-1:0] c_width    = c_cw'(WIDTH);
`endif

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [c_cw-1:0]  r_count;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [c_cw-1:0]  w_count_nxt;
    logic [WIDTH-1:0] w_shifted;
    logic             w_done;
    logic [WIDTH-1:0] w_data;
    logic             w_perr;

    // Collector state, shift register and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_SHIFT;
            r_shift <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Next-state logic; w_done marks the edge that samples a word's last bit.
    always_comb begin
        w_shifted   = {serial_in, r_shift[WIDTH-1:1]};
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_count_nxt = r_count;
        w_done      = 1'b0;
        w_data      = w_shifted;
        w_perr      = 1'b0;
        if (bit_valid) begin
            if (frame_start) begin
                // Resynchronise: stale partial bits are cleared, this is bit 0.
                w_state_nxt = ST_SHIFT;
                w_shift_nxt = {serial_in, {(WIDTH-1){1'b0}}};
                w_count_nxt = c_one;
            end else begin
                case (r_state)
`ifdef SIPO_DESER_PARITY_EN
                    ST_PARITY: begin
                        // Data is already aligned; this bit only feeds the check.
                        w_done      = 1'b1;
                        w_data      = r_shift;
                        w_perr      = (^r_shift) ^ serial_in;
                        w_count_nxt = '0;
                        w_state_nxt = ST_SHIFT;
                    end
`endif
                    default: begin
                        w_shift_nxt = w_shifted;
                        if (r_count == c_last_idx) begin
`ifdef SIPO_DESER_PARITY_EN
                            w_state_nxt = ST_PARITY;
                            w_count_nxt = c_width;
`else
                            w_done      = 1'b1;
                            w_count_nxt = '0;
`endif
                        end else begin
                            w_count_nxt = r_count + c_one;
                        end
                    end
                endcase
            end
        end
    end

    sipo_out_buffer #(
        .WIDTH (WIDTH)
    ) u_out_buffer (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (w_done),
        .in_data     (w_data),
        .in_perr     (w_perr),
        .out_ready   (out_ready),
        .clr_overrun (clr_overrun),
        .out_data    (parallel_out),
        .out_valid   (out_valid),
        .out_perr    (out_perr),
        .overrun     (overrun)
    );

    assign bit_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_sipo_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sipo_deserializer
//  Description : Directed self-checking bench for sipo_deserializer (WIDTH=8)
//                using a queue of expected words. Parity-specific steps run
//                only when SIPO_DESER_PARITY_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sipo_deserializer;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             serial_in;
    logic             bit_valid;
    logic             frame_start;
    logic             out_ready;
    logic             clr_overrun;
    logic [WIDTH-1:0] parallel_out;
    logic             out_valid;
    logic             out_perr;
    logic             overrun;
    logic [3:0]       bit_count;

    logic [WIDTH-1:0] exp_q[$];
    int               n_cmp = 0;
    int               n_bad = 0;

    sipo_deserializer #(
        .WIDTH (WIDTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .serial_in    (serial_in),
        .bit_valid    (bit_valid),
        .frame_start  (frame_start),
        .out_ready    (out_ready),
        .clr_overrun  (clr_overrun),
        .parallel_out (parallel_out),
        .out_valid    (out_valid),
        .out_perr     (out_perr),
        .overrun      (overrun),
        .bit_count    (bit_count)
    );

    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic check_pop(input string tag);
        logic [WIDTH-1:0] e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL %s: observed %0h expected <scoreboard empty>", tag, parallel_out);
        end else begin
            e = exp_q.pop_front();
            check(tag, parallel_out, e);
        end
    endtask

    task automatic send_bit(input logic b, input logic fs);
        serial_in   = b;
        frame_start = fs;
        bit_valid   = 1'b1;
        tick();
        bit_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    // Sends a full word (plus its even parity bit when enabled); out_ready
    // takes the value rdy_last for the final, word-completing edge.
    task automatic send_word(input logic [WIDTH-1:0] data, input logic fs, input logic rdy_last);
        logic [WIDTH:0] bits;
        int             n;
        bits = {^data, data};
        n    = WIDTH;
`ifdef SIPO_DESER_PARITY_EN
        n    = WIDTH + 1;
`endif
        for (int i = 0; i < n; i++) begin
            if (i == n - 1) out_ready = rdy_last;
            send_bit(bits[i], fs && (i == 0));
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        serial_in   = 1'b0;
        bit_valid   = 1'b0;
        frame_start = 1'b0;
        out_ready   = 1'b0;
        clr_overrun = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_parallel_out", parallel_out, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_perr", out_perr, 0);
        check("rst_overrun", overrun, 0);
        check("rst_bit_count", bit_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Bits 1,0,1,0,0,1,0,1 LSB-first -> 0xA5, consumer ready
        out_ready = 1'b1;
        exp_q.push_back(8'hA5);
        send_word(8'hA5, 1'b0, 1'b1);
        check("a5_valid", out_valid, 1);
        check_pop("a5_data");
        check("a5_overrun", overrun, 0);
        check("a5_perr", out_perr, 0);
        check("a5_bit_count", bit_count, 0);
        tick();
        check("a5_valid_one_cycle", out_valid, 0);

        // Overrun: 0x3C held, 0xFF dropped, then cleared
        out_ready = 1'b0;
        exp_q.push_back(8'h3C);
        send_word(8'h3C, 1'b0, 1'b0);
        check("ovr_first_valid", out_valid, 1);
        check("ovr_first_data", parallel_out, exp_q[0]);
        send_word(8'hFF, 1'b0, 1'b0);
        check("ovr_held_data", parallel_out, exp_q[0]);
        check("ovr_held_valid", out_valid, 1);
        check("ovr_flag_set", overrun, 1);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        check("ovr_flag_cleared", overrun, 0);
        check_pop("ovr_drain_data");
        out_ready = 1'b1;
        tick();
        check("ovr_drained", out_valid, 0);

        // Partial word, idle frame_start, then frame_start resync with 0x81
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        check("fs_partial_count", bit_count, 3);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("fs_no_bit_valid_ignored", bit_count, 3);
        exp_q.push_back(8'h81);
        send_word(8'h81, 1'b1, 1'b1);
        check("fs_valid", out_valid, 1);
        check_pop("fs_data");
        check("fs_overrun", overrun, 0);
        tick();
        check("fs_drained", out_valid, 0);

        // Drain on the same edge the next word (0x12) completes
        out_ready = 1'b0;
        exp_q.push_back(8'h34);
        send_word(8'h34, 1'b0, 1'b0);
        check("bb_first_valid", out_valid, 1);
        check_pop("bb_first_data");
        exp_q.push_back(8'h12);
        send_word(8'h12, 1'b0, 1'b1);
        check("bb_valid_stays", out_valid, 1);
        check_pop("bb_second_data");
        check("bb_overrun", overrun, 0);
        tick();
        check("bb_drained", out_valid, 0);

        // Asynchronous reset mid-word, then 0x5A
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        check("ar_partial_count", bit_count, 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_async_count", bit_count, 0);
        check("ar_async_valid", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(8'h5A);
        send_word(8'h5A, 1'b0, 1'b1);
        check("ar_valid", out_valid, 1);
        check_pop("ar_data");
        check("ar_bit_count", bit_count, 0);
        tick();

`ifdef SIPO_DESER_PARITY_EN
        // Explicit parity bits on 0xA5 (even number of ones)
        out_ready = 1'b1;
        exp_q.push_back(8'hA5);
        for (int i = 0; i < WIDTH; i++) send_bit(((8'hA5 >> i) & 1) != 0, 1'b0);
        check("par_wait_count", bit_count, WIDTH);
        send_bit(1'b0, 1'b0);
        check_pop("par_good_data");
        check("par_good_perr", out_perr, 0);
        tick();
        exp_q.push_back(8'hA5);
        for (int i = 0; i < WIDTH; i++) send_bit(((8'hA5 >> i) & 1) != 0, 1'b0);
        send_bit(1'b1, 1'b0);
        check_pop("par_bad_data");
        check("par_bad_perr", out_perr, 1);
        tick();
`endif

        check("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sipo_deserializer.md
SIPO_DESERIALIZER -- requirements
Module: sipo_deserializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data word width in bits (>=2).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port serial_in  input  1  serial data bit, LSB-first.
REQ-005 SHALL have port bit_valid  input  1  serial_in is sampled on this edge when high.
REQ-006 SHALL have port frame_start  input  1  with bit_valid high, the current bit is bit 0 of a new word.
REQ-007 SHALL have port out_ready  input  1  consumer accepts the held word.
REQ-008 SHALL have port clr_overrun  input  1  clears the overrun flag.
REQ-009 SHALL have port parallel_out  output  WIDTH  assembled word.
REQ-010 SHALL have port out_valid  output  1  parallel_out holds an unconsumed word.
REQ-011 SHALL have port out_perr  output  1  parity error for the held word.
REQ-012 SHALL have port overrun  output  1  sticky: a completed word was dropped.
REQ-013 SHALL have port bit_count  output  clog2(WIDTH+1)  bits collected for the word in progress.

Function
REQ-014 SHALL shift right on each bit_valid, inserting serial_in at the MSB, so that after WIDTH bits the first-received bit sits at bit 0.
REQ-015 SHALL ignore serial_in and hold all state when bit_valid is low; frame_start without bit_valid SHALL be ignored.
REQ-016 SHALL, on bit_valid with frame_start, discard any partial word, reset the count, and take the current bit as bit 0, with no error flagged.
REQ-017 SHALL use states SHIFT (collecting data bits) and, when parity is compiled in, PARITY (awaiting one parity bit); SHIFT->PARITY after bit WIDTH-1, PARITY->SHIFT on the parity bit; frame_start forces SHIFT with count 1.
REQ-018 SHALL complete a word on the edge sampling its last bit (bit WIDTH-1, or the parity bit); parallel_out/out_valid SHALL be visible the cycle after that edge (latency 1 clock).
REQ-019 SHALL hold parallel_out, out_perr and out_valid stable while out_valid=1 and out_ready=0.
REQ-020 SHALL clear out_valid on an edge with out_valid=1 and out_ready=1 unless a new word completes on that same edge, in which case the new word is loaded and out_valid stays 1.
REQ-021 SHALL, when a word completes while out_valid=1 and out_ready=0, drop the new word, keep the held word, and set overrun.
REQ-022 SHALL clear overrun on clr_overrun; a simultaneous new overrun event SHALL take priority (overrun stays 1).
REQ-023 SHALL wrap bit_count to 0 after each completed word; bit_count never exceeds WIDTH.

Reset
REQ-024 SHALL, on rst_n low, immediately set shift register, parallel_out, bit_count to 0, out_valid, out_perr, overrun to 0, state to SHIFT.
REQ-025 SHALL discard a partial word on reset mid-word; first bit after release is bit 0.

Configuration
REQ-026 SHALL support macro SIPO_DESER_PARITY_EN: defined -> one even-parity bit follows each WIDTH data bits; out_perr=1 when XOR of data and parity bit is 1; word delivered with its flag.
REQ-027 SHALL, without SIPO_DESER_PARITY_EN, omit the PARITY state, complete words after WIDTH bits, and tie out_perr to 0 (port retained).

Structure
REQ-028 SHALL place the state enum and a bit-count-width constant function in package sipo_deser_pkg.
REQ-029 SHALL implement the one-entry valid/ready holding register as sub-module sipo_out_buffer.

Verification (WIDTH=8)
REQ-030 SHALL test: bits 1,0,1,0,0,1,0,1 on consecutive cycles, out_ready=1 -> out_valid=1 for one cycle after 8th edge, parallel_out=0xA5, overrun=0.
REQ-031 SHALL test: word 0x3C completes with out_ready=0, then 0xFF completes -> parallel_out stays 0x3C, overrun=1; clr_overrun pulse -> overrun=0.
REQ-032 SHALL test: 3 bits sent, then frame_start with 8 bits of 0x81 -> parallel_out=0x81, no overrun.
REQ-033 SHALL test: out_ready=1 on the same edge the next word 0x12 completes -> out_valid stays 1, parallel_out=0x12, overrun=0.
REQ-034 SHALL test: rst_n low after 5 bits, release, send 0x5A -> parallel_out=0x5A, bit_count=0 after completion.
REQ-035 SHALL test (PARITY_EN): 0xA5 then parity 0 -> out_perr=0; 0xA5 then parity 1 -> out_perr=1.
